// File: rtl/regfile_pkg.sv
// Shared constants for the ALU operand register file: function codes,
// read-select encodings and the default register width.
package regfile_pkg;

    localparam int DATA_WIDTH = 16;

    // Register function codes
    localparam logic [2:0] FS_DEC     = 3'b000;
    localparam logic [2:0] FS_INC     = 3'b001;
    localparam logic [2:0] FS_LOAD    = 3'b010;
    localparam logic [2:0] FS_CLR     = 3'b011;
    localparam logic [2:0] FS_LOW_CLR = 3'b100;
    localparam logic [2:0] FS_LOW     = 3'b101;
    localparam logic [2:0] FS_HIGH    = 3'b110;
    localparam logic [2:0] FS_SEXT    = 3'b111;

    // Read-select encodings; the value is also the register's index in the file
    localparam logic [2:0] SEL_R1 = 3'd0;
    localparam logic [2:0] SEL_R2 = 3'd1;
    localparam logic [2:0] SEL_R3 = 3'd2;
    localparam logic [2:0] SEL_R4 = 3'd3;
    localparam logic [2:0] SEL_S1 = 3'd4;
    localparam logic [2:0] SEL_S2 = 3'd5;
    localparam logic [2:0] SEL_S3 = 3'd6;
    localparam logic [2:0] SEL_S4 = 3'd7;

endpackage

// File: rtl/register16.sv
// One 16-bit register with async active-low reset, active-high enable and
// the eight-way function decode applied to its own current value.
module register16 #(
    parameter int                           DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]        RESET_VALUE = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  E,
    input  logic [2:0]            FunSel,
    input  logic [DATA_WIDTH-1:0] I,
    output logic [DATA_WIDTH-1:0] Q
);
    import regfile_pkg::*;

    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] w_next;

    // Next-state decode; byte-lane functions assume a two-byte register
    always_comb begin
        w_next = r_q;
        case (FunSel)
            FS_DEC:     w_next = r_q - DATA_WIDTH'(1);
            FS_INC:     w_next = r_q + DATA_WIDTH'(1);
            FS_LOAD:    w_next = I;
            FS_CLR:     w_next = '0;
            FS_LOW_CLR: w_next = {{(DATA_WIDTH-8){1'b0}}, I[7:0]};
            FS_LOW:     w_next = {r_q[DATA_WIDTH-1:8], I[7:0]};
            FS_HIGH:    w_next = {I[7:0], r_q[7:0]};
            FS_SEXT:    w_next = {{(DATA_WIDTH-8){I[7]}}, I[7:0]};
            default:    w_next = r_q;
        endcase
    end

    // State update: reset wins immediately, otherwise update only when enabled
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_q <= RESET_VALUE;
        else if (E)
            r_q <= w_next;
    end

    assign Q = r_q;

endmodule

// File: rtl/register_file.sv
// ALU operand register file: R1-R4 and S1-S4, written from bus I under a
// common function code, read out through two independent 8:1 muxes.
module register_file #(
    parameter int                    DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] I,
    input  logic [2:0]            FunSel,
    input  logic [3:0]            RegSel,
    input  logic [3:0]            ScrSel,
    input  logic [2:0]            OutASel,
    input  logic [2:0]            OutBSel,
    output logic [DATA_WIDTH-1:0] OutA,
    output logic [DATA_WIDTH-1:0] OutB
);
    import regfile_pkg::*;

    localparam int NUM_REGS = 8;

    // Index k follows the read-select encoding: 0..3 = R1..R4, 4..7 = S1..S4.
    // Select buses are MSB-first (bit3 = R1/S1), hence the reversed bit order.
    logic [NUM_REGS-1:0]   w_en;
    logic [DATA_WIDTH-1:0] w_q [NUM_REGS];

    assign w_en = {~ScrSel[0], ~ScrSel[1], ~ScrSel[2], ~ScrSel[3],
                   ~RegSel[0], ~RegSel[1], ~RegSel[2], ~RegSel[3]};

    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_reg
            register16 #(
                .DATA_WIDTH  (DATA_WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_reg (
                .Clock  (Clock),
                .Reset  (Reset),
                .E      (w_en[k]),
                .FunSel (FunSel),
                .I      (I),
                .Q      (w_q[k])
            );
        end
    endgenerate

    // Zero-cycle read muxes; all 8 codes map to a register so nothing goes X
    always_comb begin
        OutA = w_q[OutASel];
        OutB = w_q[OutBSel];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: a driver applies directed and random writes and reads,
// pushing the expected OutA/OutB (from an array-based model) into a queue; a
// monitor pops and compares on every falling clock edge.
module tb_register_file;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;

    register_file dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    always #5 Clock = ~Clock;

    int errs   = 0;
    int checks = 0;

    // Reference model: m[0..3] = R1..R4, m[4..7] = S1..S4
    logic [15:0] m [8];
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register behaviour straight from the function table
    function automatic logic [15:0] apply(input logic [15:0] q, input logic [2:0] fs,
                                          input logic [15:0] d);
        int v;
        case (fs)
            3'd0: begin v = (int'(q) + 65535) % 65536; return 16'(v); end
            3'd1: begin v = (int'(q) + 1) % 65536;     return 16'(v); end
            3'd2: return d;
            3'd3: return 16'h0000;
            3'd4: return {8'h00, d[7:0]};
            3'd5: return {q[15:8], d[7:0]};
            3'd6: return {d[7:0], q[7:0]};
            default: return {(d[7] ? 8'hFF : 8'h00), d[7:0]};
        endcase
    endfunction

    // Monitor: combinational outputs are sampled mid-cycle, before the write edge
    always @(negedge Clock) begin
        if (Reset === 1'b1 && exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("OutA", OutA, e[31:16]);
            chk("OutB", OutB, e[15:0]);
        end
    end

    // One write cycle: drive, predict pre-edge reads, clock, update model
    task automatic cycle(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                         input logic [15:0] d, input logic [2:0] as, input logic [2:0] bs);
        FunSel = fs; RegSel = rs; ScrSel = ss; I = d; OutASel = as; OutBSel = bs;
        exp_q.push_back({m[as], m[bs]});
        @(posedge Clock);
        for (int k = 0; k < 4; k++) begin
            if (!rs[3-k]) m[k]   = apply(m[k], fs, d);
            if (!ss[3-k]) m[k+4] = apply(m[k+4], fs, d);
        end
        #1;
    endtask

    // Read every register through both ports without writing
    task automatic sweep();
        for (int k = 0; k < 8; k++)
            cycle(3'd2, 4'hF, 4'hF, 16'h5555, 3'(k), 3'(7 - k));
    endtask

    initial begin
        foreach (m[k]) m[k] = 16'h0000;
        Reset = 1'b0; I = '0; FunSel = '0; RegSel = 4'hF; ScrSel = 4'hF;
        OutASel = 3'd0; OutBSel = 3'd7;
        #3;
        chk("reset_outA", OutA, 16'h0000);
        chk("reset_outB", OutB, 16'h0000);
        @(posedge Clock); #2;
        Reset = 1'b1;
        @(posedge Clock); #1;

        // Load R1 and check the old value is seen during the write cycle
        cycle(3'd2, 4'b0111, 4'hF, 16'h1234, 3'd0, 3'd1);
        chk("r1_load", OutA, 16'h1234);
        cycle(3'd2, 4'b0111, 4'hF, 16'hBEEF, 3'd0, 3'd1);
        chk("r1_beef", OutA, 16'hBEEF);
        sweep();

        // Async reset mid-cycle: outputs clear before any edge
        OutASel = 3'd0; OutBSel = 3'd0;
        #1 Reset = 1'b0;
        #1 chk("async_rst_r1", OutA, 16'h0000);
        foreach (m[k]) m[k] = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            OutBSel = 3'(k);
            #0.5 chk("rst_all", OutB, 16'h0000);
        end
        // Held in reset across an edge with every enable active
        RegSel = 4'h0; ScrSel = 4'h0; FunSel = 3'd2; I = 16'hFFFF;
        @(posedge Clock); #1;
        chk("rst_hold", OutA, 16'h0000);
        RegSel = 4'hF; ScrSel = 4'hF;
        @(negedge Clock); Reset = 1'b1;
        @(posedge Clock); #1;

        // Increment/decrement wrap on R2
        cycle(3'd2, 4'b1011, 4'hF, 16'hFFFF, 3'd1, 3'd0);
        cycle(3'd1, 4'b1011, 4'hF, 16'h0000, 3'd1, 3'd0);
        chk("inc_wrap", OutA, 16'h0000);
        cycle(3'd0, 4'b1011, 4'hF, 16'h0000, 3'd1, 3'd0);
        chk("dec_wrap", OutA, 16'hFFFF);
        cycle(3'd0, 4'b1011, 4'hF, 16'h0000, 3'd1, 3'd0);
        chk("dec_fffe", OutA, 16'hFFFE);

        // Byte-lane functions on S3
        cycle(3'd2, 4'hF, 4'b1101, 16'hA5C3, 3'd6, 3'd1);
        cycle(3'd5, 4'hF, 4'b1101, 16'h1280, 3'd6, 3'd1);
        chk("low_only", OutA, 16'hA580);
        cycle(3'd6, 4'hF, 4'b1101, 16'h1280, 3'd6, 3'd1);
        chk("high_only", OutA, 16'h8080);
        cycle(3'd4, 4'hF, 4'b1101, 16'h1280, 3'd6, 3'd1);
        chk("low_clr", OutA, 16'h0080);
        cycle(3'd7, 4'hF, 4'b1101, 16'h1280, 3'd6, 3'd1);
        chk("sext", OutA, 16'hFF80);

        // Clear everything, then a fully disabled load changes nothing
        cycle(3'd3, 4'h0, 4'h0, 16'h1111, 3'd6, 3'd1);
        cycle(3'd2, 4'hF, 4'hF, 16'h5555, 3'd6, 3'd1);
        chk("no_enable", OutA, 16'h0000);
        sweep();

        // Combinational reads with no clock edge involved
        cycle(3'd2, 4'b1101, 4'hF, 16'h0007, 3'd2, 3'd4);
        cycle(3'd2, 4'hF, 4'b0111, 16'h0003, 3'd2, 3'd4);
        OutASel = 3'd2; OutBSel = 3'd4;
        #1 chk("comb_r3", OutA, 16'h0007);
        chk("comb_s1", OutB, 16'h0003);
        OutBSel = 3'd2;
        #1 chk("same_sel_a", OutA, 16'h0007);
        chk("same_sel_b", OutB, 16'h0007);

        // Random traffic
        for (int n = 0; n < 400; n++)
            cycle(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        sweep();

        repeat (2) @(posedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
